seven_seg_driver: RTL and testbench

Time-multiplexed driver for the 4-digit common-anode 7-segment display, directly downstream of the message selector. Takes the four 4-bit character codes (an3char..an0char), latches them once per frame, scans the digits one at a time with a blanking dead-time between digits, and decodes each code to hex segment patterns. All outputs are registered and active-low.

---
 rtl/seven_seg_driver.sv | 112 +++++++++++
 tb/tb_seven_seg_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_driver.sv
// seven_seg_driver: time-multiplexed scan of a 4-digit common-anode display.
// Each digit slot is REFRESH_CYCLES long. The first BLANK_CYCLES of a slot
// keep every anode off, and the segment pattern is swapped inside that
// window. The four character codes are sampled once per frame, at the start
// of the digit-3 slot, so a frame never mixes old and new characters.
// Outputs are registered from the current scan state, so the display lags
// the internal counter by one cycle.
module seven_seg_driver #(
  parameter int REFRESH_CYCLES = 16000,
  parameter int BLANK_CYCLES   = 1600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an3char,
  input  logic [3:0] an2char,
  input  logic [3:0] an1char,
  input  logic [3:0] an0char,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            CW         = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} phase_e;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      dig_q, dig_d;
  phase_e          phase_q, phase_d;
  logic [3:0][3:0] sh_q, sh_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            cnt_last;

  // Hex to active-low {a,b,c,d,e,f,g}.
  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Scan counter, digit index, blank/show phase and output next-state.
  always_comb begin
    cnt_last = (cnt_q == CNT_LAST);
    cnt_d    = cnt_last ? '0 : cnt_q + CW'(1);
    dig_d    = cnt_last ? dig_q - 2'd1 : dig_q;

    phase_d = phase_q;
    case (phase_q)
      BLANK:   if (cnt_q == BLANK_LAST) phase_d = SHOW;
      SHOW:    if (cnt_last)            phase_d = BLANK;
      default: phase_d = BLANK;
    endcase

    // Frame latch at the first cycle of the digit-3 slot. The segment load
    // below reads sh_d so digit 3 shows the freshly latched code, not the
    // previous frame's.
    sh_d = sh_q;
    if (cnt_q == '0 && dig_q == 2'd3) sh_d = {an3char, an2char, an1char, an0char};

    // Segments only change in the first cycle of a slot, which is always
    // a blanked cycle because BLANK_CYCLES >= 1.
    seg_d = seg_q;
    if (cnt_q == '0) seg_d = decode(sh_d[dig_q]);

    an_d = 4'hF;
    if (phase_q == SHOW) an_d = ~(4'b0001 << dig_q);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      dig_q   <= 2'd3;
      phase_q <= BLANK;
      sh_q    <= '0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_driver.sv
// Bench for seven_seg_driver: two instances (8/2 and the 2/1 boundary) share
// clock, reset and characters. An index-arithmetic model predicts both every
// cycle; table vectors and hand sequences cover scan, latch and reset cases.
module tb_seven_seg_driver;
  localparam int RA = 8, BA = 2;
  localparam int RB = 2, BB = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] c3 = '0, c2 = '0, c1 = '0, c0 = '0;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  seven_seg_driver #(.REFRESH_CYCLES(RA), .BLANK_CYCLES(BA)) dut_a (
    .clk(clk), .reset(reset), .an3char(c3), .an2char(c2), .an1char(c1),
    .an0char(c0), .an(an_a), .seg(seg_a), .dp(dp_a));

  seven_seg_driver #(.REFRESH_CYCLES(RB), .BLANK_CYCLES(BB)) dut_b (
    .clk(clk), .reset(reset), .an3char(c3), .an2char(c2), .an1char(c1),
    .an0char(c0), .an(an_b), .seg(seg_b), .dp(dp_b));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  logic [6:0] dec_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model: k = clock edges since release; lat = characters of current frame.
  int ka = 0, kb = 0;
  logic [3:0][3:0] lat_a = '0, lat_b = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_chk(input string tag, input int k, input int r, input int b,
                           input logic [3:0][3:0] lat, input logic [3:0] an,
                           input logic [6:0] seg, input logic dp);
    int s, d;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    if (k == 0) begin
      e_an = 4'hF; e_seg = 7'h7F;
    end else begin
      s = k - 1;
      d = 3 - (s / r) % 4;
      e_an  = (s % r < b) ? 4'hF : ~(4'b0001 << d);
      e_seg = dec_tab[lat[d]];
    end
    chk({tag, "_an"}, 32'(an), 32'(e_an));
    chk({tag, "_seg"}, 32'(seg), 32'(e_seg));
    chk({tag, "_dp"}, 32'(dp), 32'd1);
  endtask

  // One clock edge: update model with the inputs present at the edge, then check.
  task automatic tick();
    if (ka % (4 * RA) == 0) lat_a = {c3, c2, c1, c0};
    if (kb % (4 * RB) == 0) lat_b = {c3, c2, c1, c0};
    ka++; kb++;
    @(posedge clk); #1;
    model_chk("mdl_a", ka, RA, BA, lat_a, an_a, seg_a, dp_a);
    model_chk("mdl_b", kb, RB, BB, lat_b, an_b, seg_b, dp_b);
  endtask

  task automatic restart();
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_an_a", 32'(an_a), 32'hF);
    chk("rst_seg_a", 32'(seg_a), 32'h7F);
    reset = 1'b1;
    ka = 0; kb = 0;
  endtask

  // Ghosting monitor: at most one anode low, segments frozen while lit.
  logic [6:0] prev_a = 7'h7F, prev_b = 7'h7F;
  always @(negedge clk) begin
    if (reset) begin
      chk("onehot_a", 32'($countones(~an_a) <= 1), 32'd1);
      chk("onehot_b", 32'($countones(~an_b) <= 1), 32'd1);
      if (an_a != 4'hF) chk("ghost_a", 32'(seg_a), 32'(prev_a));
      if (an_b != 4'hF) chk("ghost_b", 32'(seg_b), 32'(prev_b));
    end
    prev_a = seg_a;
    prev_b = seg_b;
  end

  typedef struct {
    int         s;
    logic [3:0] an;
    logic [6:0] seg;
  } vec_t;
  vec_t tbl [15];

  initial begin
    // Scan of chars 0,1,2,3 at R=8/B=2: s is the counter state behind the output.
    tbl[0]  = '{0,  4'hF, 7'b0000001};
    tbl[1]  = '{1,  4'hF, 7'b0000001};
    tbl[2]  = '{2,  4'h7, 7'b0000001};
    tbl[3]  = '{7,  4'h7, 7'b0000001};
    tbl[4]  = '{8,  4'hF, 7'b1001111};
    tbl[5]  = '{9,  4'hF, 7'b1001111};
    tbl[6]  = '{10, 4'hB, 7'b1001111};
    tbl[7]  = '{15, 4'hB, 7'b1001111};
    tbl[8]  = '{16, 4'hF, 7'b0010010};
    tbl[9]  = '{18, 4'hD, 7'b0010010};
    tbl[10] = '{24, 4'hF, 7'b0000110};
    tbl[11] = '{26, 4'hE, 7'b0000110};
    tbl[12] = '{31, 4'hE, 7'b0000110};
    tbl[13] = '{32, 4'hF, 7'b0000001};
    tbl[14] = '{34, 4'h7, 7'b0000001};

    // Reset held while the clock runs.
    c3 = 4'h0; c2 = 4'h1; c1 = 4'h2; c0 = 4'h3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold_an_a", 32'(an_a), 32'hF);
      chk("hold_seg_a", 32'(seg_a), 32'h7F);
      chk("hold_dp_a", 32'(dp_a), 32'd1);
      chk("hold_an_b", 32'(an_b), 32'hF);
    end
    reset = 1'b1;
    ka = 0; kb = 0;

    // Table-driven scan sequence.
    foreach (tbl[i]) begin
      while (ka < tbl[i].s + 1) tick();
      chk($sformatf("scan_an_s%0d", tbl[i].s), 32'(an_a), 32'(tbl[i].an));
      chk($sformatf("scan_seg_s%0d", tbl[i].s), 32'(seg_a), 32'(tbl[i].seg));
    end

    // Asynchronous reset mid-SHOW (dut_a has an=0111 now).
    chk("pre_midrst_an", 32'(an_a), 32'h7);
    #2 reset = 1'b0;
    #1;
    chk("midrst_an_a", 32'(an_a), 32'hF);
    chk("midrst_seg_a", 32'(seg_a), 32'h7F);
    chk("midrst_an_b", 32'(an_b), 32'hF);
    @(posedge clk); #1;
    chk("midrst_hold_an", 32'(an_a), 32'hF);
    reset = 1'b1;
    ka = 0; kb = 0;
    for (int i = 0; i < 40; i++) tick();

    // Frame latch: an0char changes mid-frame, shown only from the next frame.
    c3 = 4'h5; c2 = 4'h6; c1 = 4'h7; c0 = 4'h4;
    restart();
    while (ka < 64) begin
      if (ka == 10) c0 = 4'hE;
      tick();
      if (ka == 27) begin
        chk("latch_old_an", 32'(an_a), 32'hE);
        chk("latch_old_seg", 32'(seg_a), 32'(7'b1001100));
      end
      if (ka == 59) begin
        chk("latch_new_an", 32'(an_a), 32'hE);
        chk("latch_new_seg", 32'(seg_a), 32'(7'b0110000));
      end
    end

    // Full decode on digit 3, one code per frame.
    restart();
    for (int f = 0; f < 16; f++) begin
      c3 = 4'(f);
      for (int j = 0; j < 4 * RA; j++) begin
        tick();
        if (j == 3) chk($sformatf("decode_%0h", f), 32'(seg_a), 32'(dec_tab[f]));
      end
    end

    // Randomized characters against the model.
    restart();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        c3 = 4'($urandom); c2 = 4'($urandom); c1 = 4'($urandom); c0 = 4'($urandom);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
